// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 geometry, the colour
// channel type, the counter width and the total-period derivation.
package vga_pkg;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;

   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   // Both axes fit in 10 bits (800 and 525 are the default totals)
   localparam int COUNT_W = 10;

   typedef logic [3:0]         colour_t;
   typedef logic [COUNT_W-1:0] count_t;

   // One axis period is the sum of its visible, porch and sync segments
   function automatic int axis_total(input int visible, input int front,
                                     input int sync, input int back);
      return visible + front + sync + back;
   endfunction

   localparam int DEF_H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
   localparam int DEF_V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA axis: a wrapping counter with enable, a terminal-count flag,
// an active-area flag and an active-low sync-window compare.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int TOTAL      = DEF_H_TOTAL,
   parameter int VISIBLE    = DEF_H_VISIBLE,
   parameter int SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT,
   parameter int SYNC_WIDTH = DEF_H_SYNC
)
(
   input  logic   clk,
   input  logic   reset,
   input  logic   en,
   output count_t count,
   output logic   terminal,
   output logic   active,
   output logic   sync_raw
);

   localparam count_t LAST      = count_t'(TOTAL - 1);
   localparam count_t VIS_END   = count_t'(VISIBLE);
   localparam count_t SYNC_LO   = count_t'(SYNC_START);
   localparam count_t SYNC_HI   = count_t'(SYNC_START + SYNC_WIDTH - 1);

   // Count 0..TOTAL-1 on enabled cycles, wrapping after the last position
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (en) begin
         count <= terminal ? '0 : count + count_t'(1);
      end
   end

   assign terminal = (count == LAST);
   assign active   = (count < VIS_END);
   assign sync_raw = !((count >= SYNC_LO) && (count <= SYNC_HI));

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counters, pixel
// coordinate and visible flag for the drawer, and a one-pixel-registered
// output stage for sync and colour.
// Optional macro VGA_PIXEL_DIV2_EN: pixels advance every second clk.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] red_in,
   input  logic [3:0] green_in,
   input  logic [3:0] blue_in,
   output int         col,
   output int         row,
   output logic       visible,
   output logic       frame_start,
   output logic       hsync,
   output logic       vsync,
   output logic [3:0] red,
   output logic [3:0] green,
   output logic [3:0] blue
);

   localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

   logic   pixel_en;
   count_t h_count;
   count_t v_count;
   logic   h_terminal;
   logic   v_terminal;
   logic   h_active;
   logic   v_active;
   logic   hsync_raw;
   logic   vsync_raw;

`ifdef VGA_PIXEL_DIV2_EN
   logic pixel_phase;

   // Toggle every clk so pixels advance at half the clk rate
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pixel_phase <= 1'b0;
      end else begin
         pixel_phase <= ~pixel_phase;
      end
   end

   assign pixel_en = pixel_phase;
`else
   assign pixel_en = 1'b1;
`endif

   vga_axis_counter #(
      .TOTAL      (H_TOTAL),
      .VISIBLE    (H_VISIBLE),
      .SYNC_START (H_VISIBLE + H_FRONT),
      .SYNC_WIDTH (H_SYNC)
   ) u_h_axis (
      .clk      (clk),
      .reset    (reset),
      .en       (pixel_en),
      .count    (h_count),
      .terminal (h_terminal),
      .active   (h_active),
      .sync_raw (hsync_raw)
   );

   vga_axis_counter #(
      .TOTAL      (V_TOTAL),
      .VISIBLE    (V_VISIBLE),
      .SYNC_START (V_VISIBLE + V_FRONT),
      .SYNC_WIDTH (V_SYNC)
   ) u_v_axis (
      .clk      (clk),
      .reset    (reset),
      .en       (pixel_en & h_terminal),
      .count    (v_count),
      .terminal (v_terminal),
      .active   (v_active),
      .sync_raw (vsync_raw)
   );

   assign col     = int'(h_count);
   assign row     = int'(v_count);
   assign visible = h_active & v_active;

   // Pulse for one clk in the cycle the raster wraps back to (0,0)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_start <= 1'b0;
      end else begin
         frame_start <= pixel_en & h_terminal & v_terminal;
      end
   end

   // Register sync and colour together; blanking is folded in before the
   // register so red/green/blue come straight from flops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end else if (pixel_en) begin
         hsync <= hsync_raw;
         vsync <= vsync_raw;
         red   <= visible ? red_in   : '0;
         green <= visible ? green_in : '0;
         blue  <= visible ? blue_in  : '0;
      end
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, meaning horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, meaning hsync pulse width in pixels.
REQ-004 The block SHALL have parameter H_BACK, default 48, meaning horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_VISIBLE, default 480, meaning active lines per frame.
REQ-006 The block SHALL have parameter V_FRONT, default 10, meaning vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, meaning vsync pulse width in lines.
REQ-008 The block SHALL have parameter V_BACK, default 33, meaning vertical back porch in lines.
REQ-009 The block SHALL have port clk, input, 1 bit, meaning the single system clock.
REQ-010 The block SHALL have port reset, input, 1 bit, meaning asynchronous, active-high reset.
REQ-011 The block SHALL have ports red_in, green_in and blue_in, input, 4 bits each, meaning the drawer's colour for the current col/row.
REQ-012 The block SHALL have ports col and row, output, int, meaning the current pixel coordinate fed to the drawer.
REQ-013 The block SHALL have port visible, output, 1 bit, meaning the current col/row lie inside the active area.
REQ-014 The block SHALL have port frame_start, output, 1 bit, meaning a one-clk pulse at the start of each frame.
REQ-015 The block SHALL have ports hsync and vsync, output, 1 bit each, meaning active-low sync signals to the connector.
REQ-016 The block SHALL have ports red, green and blue, output, 4 bits each, meaning the registered pixel colour to the DAC.

Function
REQ-017 The block SHALL advance its pixel counters only on cycles where pixel_en is 1.
REQ-018 The horizontal counter hcount SHALL run from 0 to H_TOTAL-1 (800 by default) and then wrap to 0.
REQ-019 The vertical counter vcount SHALL increment only when hcount wraps, run from 0 to V_TOTAL-1 (525 by default), and then wrap to 0.
REQ-020 col SHALL equal hcount and row SHALL equal vcount, driven directly from the counter registers.
REQ-021 visible SHALL be 1 if and only if hcount < H_VISIBLE and vcount < V_VISIBLE.
REQ-022 The block SHALL compute an hsync_raw signal that is 0 when hcount is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751 by default) and 1 otherwise.
REQ-023 The block SHALL compute a vsync_raw signal that is 0 when vcount is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491 by default) and 1 otherwise.
REQ-024 The output stage SHALL register red_in, green_in, blue_in, hsync_raw, vsync_raw and visible together on each pixel_en, giving a latency of exactly one pixel from col/row to red/green/blue/hsync/vsync.
REQ-025 When the registered visible is 0, red, green and blue SHALL be forced to 0 regardless of the input colour.
REQ-026 frame_start SHALL be 1 for exactly one clk cycle, namely the cycle in which the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
REQ-027 The first frame_start SHALL occur only after a full frame has completed following reset; no frame_start SHALL be issued at reset release.
REQ-028 All counter arithmetic SHALL use unsigned 10-bit registers, and H_TOTAL and V_TOTAL SHALL be derived as the sum of their four respective parameters.

Reset
REQ-029 Asserting reset SHALL asynchronously clear hcount, vcount, the pixel_en phase, frame_start, red, green and blue to 0.
REQ-030 Asserting reset SHALL asynchronously set hsync and vsync to 1, the inactive level.
REQ-031 A reset asserted mid-frame SHALL abort the frame immediately, and the block SHALL restart at (0,0) on the first clk edge after reset release.

Configuration
REQ-032 When macro VGA_PIXEL_DIV2_EN is defined, pixel_en SHALL toggle every clk, so that pixels advance at clk/2 (50 MHz to 25 MHz) and every output holds its value for 2 clks.
REQ-033 When VGA_PIXEL_DIV2_EN is undefined, pixel_en SHALL be tied to 1, so that one pixel advances per clk.

Structure
REQ-034 A shared package vga_pkg SHALL hold the default timing constants, the colour typedef (4-bit channel) and the H_TOTAL/V_TOTAL derivation.
REQ-035 The block SHALL contain one sub-module, vga_axis_counter (a wrapping counter with enable, terminal-count output and sync-window compare), instantiated once for the horizontal axis and once for the vertical axis.

Verification
REQ-036 Release reset, then count clks between successive frame_start pulses: the result SHALL be 840000 with VGA_PIXEL_DIV2_EN and 420000 without it.
REQ-037 Observe line 0: hsync SHALL fall one pixel after col=656 and SHALL stay low for exactly 96 pixels.
REQ-038 Observe vsync across a frame: it SHALL be low for exactly 2 lines, starting one pixel after row=490, col=0.
REQ-039 Drive red_in=F, green_in=0, blue_in=A at col=0, row=0: the output SHALL be red=F, blue=A one pixel later; at col=640 the output SHALL be red=0, green=0, blue=0.
REQ-040 Assert reset at row=200, col=300: the outputs SHALL immediately be hsync=1, vsync=1 and rgb=0; after release, col/row SHALL restart at 0/0 and the next frame_start SHALL arrive one full frame later.
